// File: rtl/agu_pkg.sv
// Shared types and helpers for the AGU address-update engine.
// The reverse-carry option is controlled by the AGU_BITREV_EN macro (see agu_mod_alu).
package agu_pkg;

    localparam int AW = 16;
    localparam int RW = 2;

    typedef enum logic [2:0] {
        AGU_M_NOP    = 3'b000,
        AGU_M_INC    = 3'b001,
        AGU_M_DEC    = 3'b010,
        AGU_M_ADDN   = 3'b011,
        AGU_M_SUBN   = 3'b100,
        AGU_M_PREDEC = 3'b101,
        AGU_M_IDX    = 3'b110,
        AGU_M_RSV    = 3'b111
    } agu_mode_e;

    localparam logic [AW-1:0] M_LINEAR = 16'hFFFF;
    localparam logic [AW-1:0] M_BITREV = 16'h0000;

    typedef struct packed {
        logic [RW-1:0] idx;
        agu_mode_e     mode;
        logic [AW-1:0] r;
        logic [AW-1:0] n;
        logic [AW-1:0] m;
    } agu_s1_t;

    // Smallest all-ones mask covering m: the low k bits cleared to form the modulo base.
    function automatic logic [AW-1:0] mod_mask(input logic [AW-1:0] m);
        logic [AW-1:0] x;
        x = m;
        x = x | (x >> 1);
        x = x | (x >> 2);
        x = x | (x >> 4);
        x = x | (x >> 8);
        return x;
    endfunction

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] o;
        for (int i = 0; i < AW; i++) begin
            o[i] = v[AW-1-i];
        end
        return o;
    endfunction

endpackage

// File: rtl/agu_mod_alu.sv
// Combinational address arithmetic: linear, modulo and (with AGU_BITREV_EN) reverse-carry.
// Offset is given as magnitude plus direction so the modulo range test works on |off|.
module agu_mod_alu
    import agu_pkg::*;
(
    input  logic [AW-1:0] r,
    input  logic [AW-1:0] off_mag,
    input  logic          off_neg,
    input  logic [AW-1:0] m,
    output logic [AW-1:0] result
);

    logic [AW-1:0]        lin_s;
    logic [AW-1:0]        mask_s;
    logic [AW-1:0]        base_s;
    logic [AW:0]          size_s;
    logic                 is_mod_s;
    logic                 too_big_s;
    logic signed [AW+1:0] sum_s;
    logic signed [AW+1:0] lo_s;
    logic signed [AW+1:0] hi_s;
    logic signed [AW+1:0] wrap_s;

    // Result selection; sums are widened and signed so wrap tests see under/overflow.
    always_comb begin
        lin_s     = off_neg ? (r - off_mag) : (r + off_mag);
        mask_s    = mod_mask(m);
        base_s    = r & ~mask_s;
        size_s    = {1'b0, m} + {{AW{1'b0}}, 1'b1};
        is_mod_s  = (m != {AW{1'b0}}) && !m[AW-1];
        too_big_s = ({1'b0, off_mag} > size_s);
        sum_s     = off_neg ? ($signed({2'b00, r}) - $signed({2'b00, off_mag}))
                            : ($signed({2'b00, r}) + $signed({2'b00, off_mag}));
        lo_s      = $signed({2'b00, base_s});
        hi_s      = lo_s + $signed({2'b00, m});
        if (sum_s > hi_s) begin
            wrap_s = sum_s - $signed({1'b0, size_s});
        end else if (sum_s < lo_s) begin
            wrap_s = sum_s + $signed({1'b0, size_s});
        end else begin
            wrap_s = sum_s;
        end
        if (is_mod_s && !too_big_s) begin
            result = wrap_s[AW-1:0];
`ifdef AGU_BITREV_EN
        end else if (m == M_BITREV) begin
            result = off_neg ? bitrev(bitrev(r) - bitrev(off_mag))
                             : bitrev(bitrev(r) + bitrev(off_mag));
`endif
        end else begin
            result = lin_s;
        end
    end

endmodule

// File: rtl/agu_addr_update.sv
// AGU address-update engine: 2-stage pipeline reading Rn/Nn/Mn, producing EA and Rn write-back.
// Reverse-carry addressing for Mn=0 is built only when AGU_BITREV_EN is defined.
module agu_addr_update
    import agu_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [RW-1:0] req_reg,
    input  logic [2:0]    req_mode,
    output logic [RW-1:0] rd_addr,
    input  logic [AW-1:0] r_rdata,
    input  logic [AW-1:0] n_rdata,
    input  logic [AW-1:0] m_rdata,
    output logic          wb_write,
    output logic [RW-1:0] wb_addr,
    output logic [AW-1:0] wb_data,
    output logic          ea_valid,
    input  logic          ea_ready,
    output logic [AW-1:0] ea_addr,
    output logic          busy
);

    agu_s1_t       s1_r;
    logic          s1_valid_r;
    logic          ea_valid_r;
    logic [AW-1:0] ea_addr_r;

    logic          s2_adv_s;
    logic          s1_adv_s;
    logic          accept_s;
    logic [AW-1:0] r_in_s;
    logic [AW-1:0] ea_mag_s;
    logic          ea_neg_s;
    logic          ea_use_s;
    logic [AW-1:0] upd_mag_s;
    logic          upd_neg_s;
    logic          upd_en_s;
    logic [AW-1:0] ea_alu_s;
    logic [AW-1:0] upd_alu_s;
    logic [AW-1:0] ea_s;
    logic [AW-1:0] upd_s;

    assign s2_adv_s  = !ea_valid_r || ea_ready;
    assign s1_adv_s  = s1_valid_r && s2_adv_s;
    assign req_ready = !s1_valid_r || s2_adv_s;
    assign accept_s  = req_valid && req_ready;
    assign rd_addr   = req_reg;
    assign ea_valid  = ea_valid_r;
    assign ea_addr   = ea_addr_r;
    assign busy      = s1_valid_r || ea_valid_r;

    // Mode decode into offsets for the EA and update ALUs.
    always_comb begin
        ea_mag_s  = {AW{1'b0}};
        ea_neg_s  = 1'b0;
        ea_use_s  = 1'b0;
        upd_mag_s = {AW{1'b0}};
        upd_neg_s = 1'b0;
        upd_en_s  = 1'b0;
        case (s1_r.mode)
            AGU_M_INC: begin
                upd_mag_s = AW'(1'b1);
                upd_en_s  = 1'b1;
            end
            AGU_M_DEC: begin
                upd_mag_s = AW'(1'b1);
                upd_neg_s = 1'b1;
                upd_en_s  = 1'b1;
            end
            AGU_M_ADDN: begin
                upd_mag_s = s1_r.n;
                upd_en_s  = 1'b1;
            end
            AGU_M_SUBN: begin
                upd_mag_s = s1_r.n;
                upd_neg_s = 1'b1;
                upd_en_s  = 1'b1;
            end
            AGU_M_PREDEC: begin
                ea_mag_s = AW'(1'b1);
                ea_neg_s = 1'b1;
                ea_use_s = 1'b1;
                upd_en_s = 1'b1;
            end
            AGU_M_IDX: begin
                ea_mag_s = s1_r.n;
                ea_use_s = 1'b1;
            end
            default: begin
                ea_use_s = 1'b0;
            end
        endcase
    end

    agu_mod_alu u_ea_alu (
        .r       (s1_r.r),
        .off_mag (ea_mag_s),
        .off_neg (ea_neg_s),
        .m       (s1_r.m),
        .result  (ea_alu_s)
    );

    agu_mod_alu u_upd_alu (
        .r       (s1_r.r),
        .off_mag (upd_mag_s),
        .off_neg (upd_neg_s),
        .m       (s1_r.m),
        .result  (upd_alu_s)
    );

    // Pre-decrement writes back the same value it uses as EA.
    always_comb begin
        ea_s     = ea_use_s ? ea_alu_s : s1_r.r;
        upd_s    = (s1_r.mode == AGU_M_PREDEC) ? ea_alu_s : upd_alu_s;
        wb_write = s1_adv_s && upd_en_s;
        wb_addr  = wb_write ? s1_r.idx : {RW{1'b0}};
        wb_data  = wb_write ? upd_s : {AW{1'b0}};
        r_in_s   = (wb_write && (req_reg == s1_r.idx)) ? upd_s : r_rdata;
    end

    // Stage 1: capture the request and operands; Rn is forwarded from the write landing this edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_r       <= '{idx: req_reg, mode: agu_mode_e'(req_mode),
                            r: r_in_s, n: n_rdata, m: m_rdata};
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: EA output register with valid/ready hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ea_valid_r <= 1'b0;
            ea_addr_r  <= {AW{1'b0}};
        end else if (s2_adv_s) begin
            ea_valid_r <= s1_valid_r;
            ea_addr_r  <= s1_valid_r ? ea_s : ea_addr_r;
        end else begin
            ea_valid_r <= ea_valid_r;
        end
    end

endmodule
